// File: rtl/led_scan_drv_pkg.sv
// rtl/led_scan_drv_pkg.sv - shared constants, FSM encoding and width helper for the LED scan driver
package led_scan_pkg;

  localparam int C_PWM_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // Minimum 1 so single-row/column builds still get a legal vector width.
  function automatic int log2_ceil(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/led_scan_drv_if.sv
// rtl/led_scan_drv_if.sv - game-core side and pin side signals of the LED scan driver
interface led_scan_drv_if
  import led_scan_pkg::*;
#(
  parameter int C_ROW_N = 3,
  parameter int C_COL_N = 6
);

  logic                         EN_i;
  logic [C_ROW_N*C_COL_N-1:0]   LEDs_ON_i;
  logic [C_PWM_W-1:0]           BRIGHT_i;
  logic [C_ROW_N-1:0]           ROWs_o;
  logic [C_COL_N-1:0]           COLs_o;
  logic                         FRAME_o;

  modport master (
    output EN_i, LEDs_ON_i, BRIGHT_i,
    input  ROWs_o, COLs_o, FRAME_o
  );

  modport slave (
    input  EN_i, LEDs_ON_i, BRIGHT_i,
    output ROWs_o, COLs_o, FRAME_o
  );

endinterface

// File: rtl/led_scan_drv_timer.sv
// rtl/led_scan_drv_timer.sv - slot/row counters, blank/on FSM, PWM counter and frame-start strobe
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter  int C_ROW_N   = 3,
  parameter  int C_DWELL_N = 45_000,
  parameter  int C_BLANK_N = 512,
  localparam int C_ROW_W   = log2_ceil(C_ROW_N),
  localparam int C_SLOT_W  = log2_ceil(C_DWELL_N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [C_ROW_W-1:0] row_idx,
  output logic               on,
  output logic [C_PWM_W-1:0] pwm_ctr,
  output logic               frame_stb
);

  localparam logic [C_SLOT_W-1:0] SLOT_LAST  = C_SLOT_W'(C_DWELL_N - 1);
  localparam logic [C_SLOT_W-1:0] BLANK_LAST = C_SLOT_W'(C_BLANK_N - 1);
  localparam logic [C_ROW_W-1:0]  ROW_LAST   = C_ROW_W'(C_ROW_N - 1);

  logic [C_SLOT_W-1:0] slot_ctr;
  scan_state_t         state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_ctr <= '0;
      row_idx  <= '0;
      pwm_ctr  <= '0;
      state    <= ST_BLANK;
    end else if (!en) begin
      slot_ctr <= '0;
      row_idx  <= '0;
      pwm_ctr  <= '0;
      state    <= ST_BLANK;
    end else begin
      if (slot_ctr == SLOT_LAST) begin
        slot_ctr <= '0;
        row_idx  <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
        state    <= ST_BLANK;
      end else begin
        slot_ctr <= slot_ctr + 1'b1;
        if (slot_ctr == BLANK_LAST) state <= ST_ON;
      end
      // Held at zero through the blank window so every ON window starts at PWM phase 0.
      pwm_ctr <= (state == ST_ON) ? pwm_ctr + 1'b1 : '0;
    end
  end

  assign on        = (state == ST_ON);
  assign frame_stb = en && (row_idx == '0) && (slot_ctr == '0);

endmodule

// File: rtl/led_scan_drv.sv
// rtl/led_scan_drv.sv - 3x6 multiplexed LED matrix driver with blanking, PWM and per-frame snapshot
module led_scan_drv
  import led_scan_pkg::*;
#(
  parameter int C_F_CK    = 135_000_000,
  parameter int C_ROW_N   = 3,
  parameter int C_COL_N   = 6,
  parameter int C_DWELL_N = 45_000,
  parameter int C_BLANK_N = 512
) (
  input  logic          CK_i,
  input  logic          ARST_i,
  led_scan_drv_if.slave bus
);

  localparam int C_ROW_W = log2_ceil(C_ROW_N);

  if (C_F_CK <= 0 || C_BLANK_N < 1 || C_DWELL_N < C_BLANK_N + 16) begin : g_cfg_err
    $error("led_scan_drv: illegal clock/dwell/blank configuration");
  end

  logic [C_ROW_W-1:0]         row_idx;
  logic                       on;
  logic [C_PWM_W-1:0]         pwm_ctr;
  logic                       frame_stb;

  logic [C_ROW_N*C_COL_N-1:0] snap;
  logic [C_PWM_W-1:0]         snap_br;
  logic [C_ROW_N-1:0]         rows_q;
  logic [C_COL_N-1:0]         cols_q;
  logic                       frame_q;

  led_scan_timer #(
    .C_ROW_N   (C_ROW_N),
    .C_DWELL_N (C_DWELL_N),
    .C_BLANK_N (C_BLANK_N)
  ) u_timer (
    .clk       (CK_i),
    .rst       (ARST_i),
    .en        (bus.EN_i),
    .row_idx   (row_idx),
    .on        (on),
    .pwm_ctr   (pwm_ctr),
    .frame_stb (frame_stb)
  );

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      snap    <= '0;
      snap_br <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_stb;
      if (frame_stb) begin
        snap    <= bus.LEDs_ON_i;
        snap_br <= bus.BRIGHT_i;
      end
      // Gating with EN here darkens the pins on the very next cycle after EN drops.
      if (bus.EN_i && on) begin
        rows_q <= C_ROW_N'(1) << row_idx;
        cols_q <= snap[int'(row_idx)*C_COL_N +: C_COL_N] & {C_COL_N{pwm_ctr <= snap_br}};
      end else begin
        rows_q <= '0;
        cols_q <= '0;
      end
    end
  end

  assign bus.ROWs_o  = rows_q;
  assign bus.COLs_o  = cols_q;
  assign bus.FRAME_o = frame_q;

endmodule

// File: doc/led_scan_drv.md
Name: led_scan_drv

Overview:
- Downstream stage of the Planet Empire game core.
- Consumes the 18-bit LED-on vector and drives a 3-row x 6-column multiplexed LED matrix, one row active at a time.
- Adds anti-ghost blanking, global 16-level PWM brightness, and a per-frame snapshot so the display never tears.
- Sits between the game core and the board pins.

Parameters:
- C_F_CK, 135_000_000, input clock frequency in Hz (informational; used for sanity assertions only).
- C_ROW_N, 3, number of matrix rows.
- C_COL_N, 6, number of matrix columns; C_ROW_N*C_COL_N is the LED count.
- C_DWELL_N, 45_000, clock cycles per row slot (default gives 1 kHz frame rate); legal range is C_BLANK_N+16 or more.
- C_BLANK_N, 512, cycles at the start of each slot with all rows and columns off.

Ports:
- CK_i, in, 1, clock.
- ARST_i, in, 1, asynchronous active-high reset.
- EN_i, in, 1, scan enable; 0 means the display is dark and the scan is held at the frame start.
- LEDs_ON_i, in, C_ROW_N*C_COL_N, LED-on vector; bit r*C_COL_N+c maps to row r, column c.
- BRIGHT_i, in, 4, brightness; duty is (BRIGHT_i+1)/16 of the on window.
- ROWs_o, out, C_ROW_N, row drive, active high, at most one bit set.
- COLs_o, out, C_COL_N, column sink enable, active high.
- FRAME_o, out, 1, one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (ARST_i=1, asynchronous):
  - ROWs_o=0, COLs_o=0, FRAME_o=0.
  - SLOT_CTR=0, ROW_IDX=0, PWM_CTR=0, state BLANK.
  - Snapshot registers SNAP=0 and SNAP_BR=0.
- Internal state:
  - SLOT_CTR counts 0..C_DWELL_N-1 and wraps.
  - ROW_IDX counts 0..C_ROW_N-1, advancing when SLOT_CTR wraps; it wraps to 0 after the last row.
  - FSM state is BLANK while SLOT_CTR<C_BLANK_N, otherwise ON.
- Snapshot:
  - On every enabled cycle where ROW_IDX=0 and SLOT_CTR=0: SNAP<=LEDs_ON_i, SNAP_BR<=BRIGHT_i, FRAME_o=1 on the next cycle.
  - Changes to LEDs_ON_i or BRIGHT_i mid-frame have no visible effect until the next frame.
- PWM:
  - PWM_CTR is 4 bits. It is cleared on entry to ON and then increments every ON cycle, wrapping 15->0.
  - Column gate G = (PWM_CTR <= SNAP_BR).
- Outputs are registered, with 1-cycle latency from the internal state:
  - BLANK: ROWs_o=0 and COLs_o=0.
  - ON: ROWs_o=one-hot(ROW_IDX); COLs_o = SNAP[ROW_IDX*C_COL_N +: C_COL_N] & {C_COL_N{G}}.
- Break-before-make: rows and columns are both 0 for exactly C_BLANK_N cycles between any two row activations. ROWs_o never has two bits set, including across the wrap from the last row to row 0.
- EN_i=0:
  - Next cycle, all outputs are 0.
  - SLOT_CTR, ROW_IDX and PWM_CTR are forced to 0; SNAP is held.
- EN_i 0->1: the first enabled cycle is frame start (snapshot, FRAME_o pulse next cycle, row 0 blank).
- Reset mid-slot: outputs go to 0 immediately (asynchronously). After release the scan restarts from the frame start if EN_i=1.
- Frame period: C_ROW_N*C_DWELL_N cycles.
- Row-on cycles per slot: C_DWELL_N-C_BLANK_N.
- Lit cycles per slot: sum over each 16-cycle PWM window of (SNAP_BR+1), plus a partial final window.

Decomposition:
- Package led_scan_pkg: log2 constant function, FSM state encoding (BLANK=1'b0, ON=1'b1), C_PWM_W=4.
- One natural sub-module, led_scan_timer: SLOT_CTR/ROW_IDX/FSM/frame-start generation with EN clear. It outputs ROW_IDX, ON, PWM_CTR and FRAME_STB.
- The top level holds the snapshot registers and the output decode/registering.

Test Plan (debug parameters C_DWELL_N=20, C_BLANK_N=4, C_ROW_N=3, C_COL_N=6, frame=60 cycles):
- Reset release, EN_i=1, LEDs_ON_i=18'h3FFFF, BRIGHT_i=15 -> FRAME_o pulses every 60 cycles. Each row is high for 16 consecutive cycles after 4 dark cycles, in order 0,1,2,0. COLs_o=6'h3F throughout ON.
- LEDs_ON_i=18'h0_0C21 (row0=6'h21, row1=6'h30, row2=0), BRIGHT_i=15 -> COLs_o=6'h21 with row0, 6'h30 with row1, 0 with row2. No row overlap at any slot boundary.
- BRIGHT_i=3 -> within each 16-cycle ON window, COLs_o is non-zero for exactly the first 4 cycles.
- BRIGHT_i=0 -> exactly 1 lit cycle per window.
- Change LEDs_ON_i from 18'h3FFFF to 0 at cycle 30 of a frame -> the display is unchanged until the next FRAME_o; the following frame is fully dark.
- Drop EN_i at cycle 25 -> outputs 0 from cycle 26. Re-assert EN_i -> FRAME_o pulses 1 cycle later and row 0 lights after 4 blank cycles.
- Assert ARST_i mid-ON for 2 cycles -> ROWs_o and COLs_o are 0 within the same cycle. After release the scan restarts at row 0 with SNAP=0 until the new snapshot is taken.
